load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the data-memory interface. Turns core load/store requests (RV32I LB/LH/LW/LBU/LHU/SB/SH/SW) into word-granular MEM_* read and write cycles.
- The memory has one combinational 32-bit read port and one 32-bit, posedge-committed, little-endian write port with no byte enables. Sub-word stores are therefore done as read-modify-write.
- Sits between the execute stage and main memory.

Parameters:
- XLEN, 32, data and address width.
- TRAP_MISALIGNED, 1: when 1, misaligned LH/LHU/SH/LW/SW return an error with no memory access; when 0, the address is silently aligned down.

Ports:
- SYS_clk  in  1  system clock.
- SYS_reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit can accept a request.
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data (low bits used for B/H).
- resp_valid  out  1  response valid.
- resp_ready  in  1  core accepts response.
- resp_rdata  out  XLEN  load result, extended; 0 for stores.
- resp_error  out  1  misaligned or illegal funct3.
- MEM_read_address  out  XLEN  word-aligned read address.
- MEM_read_data  in  XLEN  combinational read data.
- MEM_write_enable  out  1  write strobe.
- MEM_write_address  out  XLEN  word-aligned write address.
- MEM_write_data  out  XLEN  full word to write.

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP.
- req_ready = (state==IDLE) and SYS_reset deasserted. A request is accepted on a clock edge with req_valid and req_ready both high.
- On accept, latch: aligned word address waddr = {addr[XLEN-1:2],2'b00}, byte offset off = addr[1:0], funct3, write flag, wdata.
- Legality:
  - funct3 011, 110 or 111 is illegal.
  - Loads of BU/HU with req_write=1 are illegal.
  - Misaligned means H with off[0]=1, or W with off!=0.
  - An illegal or (TRAP_MISALIGNED=1) misaligned request goes IDLE->RESP with resp_error=1 and resp_rdata=0. No MEM_write_enable pulse.
- Load: IDLE->READ.
  - In READ, MEM_read_address=waddr. Sample MEM_read_data at the edge, select byte/half by off, sign-extend (B/H) or zero-extend (BU/HU) into resp_rdata, go to RESP.
  - Latency: resp_valid rises 2 cycles after accept.
- SW: IDLE->WRITE.
  - In WRITE, MEM_write_enable=1 for exactly one cycle, MEM_write_address=waddr, MEM_write_data=wdata. Then go to RESP.
  - resp_valid rises 2 cycles after accept.
- SB/SH: IDLE->READ->WRITE->RESP.
  - The READ sample is merged: only the target byte/half (lanes chosen by off) is replaced by wdata[7:0]/[15:0]; other lanes are preserved.
  - resp_valid rises 3 cycles after accept.
- RESP: resp_valid=1, outputs held stable until resp_ready. On handshake go to IDLE.
- Back-to-back: a new request can be accepted no earlier than the cycle after the RESP handshake. No pipelining.
- MEM_read_address = waddr in READ, else 0. MEM_write_* = 0 outside WRITE.
- Reset values (async assert): state IDLE, resp_valid 0, resp_rdata 0, resp_error 0, MEM_write_enable 0, MEM_write_address 0, MEM_write_data 0, MEM_read_address 0, all latched request registers 0.
- Reset mid-operation: MEM_write_enable drops immediately. A WRITE cycle cut by reset before its edge commits nothing. A pending response is discarded.
- resp_ready held high with no pending response: ignored.

Decomposition:
- Shared package/header (global.vh): funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU), FSM state encodings, XLEN.
- One natural sub-module: lsu_lane_align. It is combinational and holds:
  - load extraction and extension (word, off, funct3 -> rdata);
  - store merge (old word, wdata, off, funct3 -> new word).
- The FSM stays in load_store_unit.

Test Plan:
- Memory word at 0x100 = 0x80FF_7F01. LB 0x103 -> 0xFFFF_FF80. LBU 0x103 -> 0x0000_0080. LH 0x102 -> 0xFFFF_80FF. resp_valid 2 cycles after accept.
- SW 0x200 data 0xDEAD_BEEF -> one MEM_write_enable pulse, addr 0x200, data 0xDEAD_BEEF. resp_error 0. LW 0x200 then returns 0xDEAD_BEEF.
- Word 0x200 = 0x1122_3344. SB 0x201 data 0xAA -> write 0x1122_AA44. SH 0x202 data 0xBEEF -> write 0xBEEF_AA44. Each resp_valid 3 cycles after accept.
- TRAP_MISALIGNED=1: LW 0x202 and SH 0x203 -> resp_error=1, rdata 0, no write pulse. funct3=011 -> resp_error=1.
- resp_ready held low 5 cycles -> resp_valid/resp_rdata stable, req_ready 0. After handshake, req_ready 1 next cycle.
- Assert SYS_reset low during WRITE of an SB -> MEM_write_enable 0 immediately, target word unchanged, all outputs at reset values. After release, a fresh LW is serviced normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 sizes, FSM states and
// the request legality helpers used at accept time.
package load_store_unit_pkg;

  localparam int LSU_XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_t;

  // Unsigned variants only exist as loads.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic wr);
    logic bad;
    case (f3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = wr;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (((f3 == F3_H) || (f3 == F3_HU)) && off[0]) ||
           ((f3 == F3_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/half lane handling: load extraction with sign/zero extension and
// read-modify-write merge of a sub-word store into the old memory word.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  b_lane;
  logic [15:0] h_lane;

  always_comb begin
    b_lane = word[{off, 3'b000} +: 8];
    h_lane = off[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    load_data = {{24{b_lane[7]}}, b_lane};
      F3_BU:   load_data = {24'd0, b_lane};
      F3_H:    load_data = {{16{h_lane[15]}}, h_lane};
      F3_HU:   load_data = {16'd0, h_lane};
      default: load_data = word;
    endcase

    store_word = word;
    case (funct3)
      F3_B: store_word[{off, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (off[1]) store_word[31:16] = wdata[15:0];
        else        store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: turns core load/store requests into word reads,
// word writes, or read-modify-write sequences for sub-word stores.
//
// state   | meaning
// S_IDLE  | ready for a request
// S_READ  | memory read port driven; load result or store merge sampled
// S_WRITE | one-cycle write strobe with the final word
// S_RESP  | response held until resp_ready
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN            = LSU_XLEN,
  parameter bit TRAP_MISALIGNED = 1'b1
) (
  input  logic            SYS_clk,
  input  logic            SYS_reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_error,
  output logic [XLEN-1:0] MEM_read_address,
  input  logic [XLEN-1:0] MEM_read_data,
  output logic            MEM_write_enable,
  output logic [XLEN-1:0] MEM_write_address,
  output logic [XLEN-1:0] MEM_write_data
);

  lsu_state_t state, state_next;

  logic [XLEN-1:2] waddr;
  logic [1:0]      off;
  logic [2:0]      funct3;
  logic            wr;
  logic [XLEN-1:0] wword;   // store data on accept, merged word after READ
  logic [XLEN-1:0] rdata;
  logic            error;

  logic            accept;
  logic            req_bad;
  logic [1:0]      eff_off;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] store_word;

  assign req_ready = (state == S_IDLE) && SYS_reset;
  assign accept    = req_valid && req_ready;
  assign req_bad   = f3_illegal(req_funct3, req_write) ||
                     (TRAP_MISALIGNED && f3_misaligned(req_funct3, req_addr[1:0]));

  // Without trapping, misaligned halves/words fall back to their aligned lane.
  always_comb begin
    eff_off = req_addr[1:0];
    if (req_funct3 == F3_W)
      eff_off = 2'b00;
    else if ((req_funct3 == F3_H) || (req_funct3 == F3_HU))
      eff_off = {req_addr[1], 1'b0};
  end

  lsu_lane_align u_lane_align (
    .word       (MEM_read_data),
    .wdata      (wword),
    .off        (off),
    .funct3     (funct3),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) state <= S_IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_bad)                                  state_next = S_RESP;
          else if (req_write && (req_funct3 == F3_W))   state_next = S_WRITE;
          else                                          state_next = S_READ;
        end
      end
      S_READ:  state_next = wr ? S_WRITE : S_RESP;
      S_WRITE: state_next = S_RESP;
      S_RESP:  if (resp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      waddr  <= '0;
      off    <= '0;
      funct3 <= '0;
      wr     <= 1'b0;
      wword  <= '0;
      rdata  <= '0;
      error  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            waddr  <= req_addr[XLEN-1:2];
            off    <= eff_off;
            funct3 <= req_funct3;
            wr     <= req_write;
            wword  <= req_wdata;
            rdata  <= '0;
            error  <= req_bad;
          end
        end
        S_READ: begin
          if (wr) wword <= store_word;
          else    rdata <= load_data;
        end
        default: ;
      endcase
    end
  end

  assign resp_valid        = (state == S_RESP);
  assign resp_rdata        = rdata;
  assign resp_error        = error;
  assign MEM_read_address  = (state == S_READ)  ? {waddr, 2'b00} : '0;
  assign MEM_write_enable  = (state == S_WRITE);
  assign MEM_write_address = (state == S_WRITE) ? {waddr, 2'b00} : '0;
  assign MEM_write_data    = (state == S_WRITE) ? wword : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a small behavioural memory
// with a combinational read port and posedge write port.
module tb_load_store_unit;

  logic        SYS_clk;
  logic        SYS_reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] MEM_read_address;
  logic [31:0] MEM_read_data;
  logic        MEM_write_enable;
  logic [31:0] MEM_write_address;
  logic [31:0] MEM_write_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [1024];
  int          wr_count = 0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;
  logic        poke_en = 1'b0;
  logic [31:0] poke_addr = '0;
  logic [31:0] poke_data = '0;

  load_store_unit #(.XLEN(32), .TRAP_MISALIGNED(1'b1)) dut (
    .SYS_clk           (SYS_clk),
    .SYS_reset         (SYS_reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_funct3        (req_funct3),
    .req_write         (req_write),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_rdata        (resp_rdata),
    .resp_error        (resp_error),
    .MEM_read_address  (MEM_read_address),
    .MEM_read_data     (MEM_read_data),
    .MEM_write_enable  (MEM_write_enable),
    .MEM_write_address (MEM_write_address),
    .MEM_write_data    (MEM_write_data)
  );

  initial begin
    SYS_clk = 1'b0;
    forever #5 SYS_clk = ~SYS_clk;
  end

  assign MEM_read_data = mem[MEM_read_address[11:2]];

  always @(posedge SYS_clk) begin
    if (MEM_write_enable) begin
      mem[MEM_write_address[11:2]] <= MEM_write_data;
      wr_count   <= wr_count + 1;
      last_waddr <= MEM_write_address;
      last_wdata <= MEM_write_data;
    end else if (poke_en) begin
      mem[poke_addr[11:2]] <= poke_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [31:0] addr, input logic [31:0] data);
    @(negedge SYS_clk);
    poke_en   = 1'b1;
    poke_addr = addr;
    poke_data = data;
    @(posedge SYS_clk);
    #1;
    poke_en = 1'b0;
  endtask

  // Issue one request; edges = clock edges after the accepting edge until
  // resp_valid is seen. Optionally completes the response handshake.
  task automatic do_req(input logic [2:0] f3, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input bit hs,
                        output int edges, output logic [31:0] rd, output logic er,
                        output logic [31:0] ra);
    @(negedge SYS_clk);
    req_funct3 = f3;
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    @(posedge SYS_clk);
    #1;
    req_valid = 1'b0;
    ra = MEM_read_address;
    edges = 0;
    while (!resp_valid && edges < 10) begin
      @(posedge SYS_clk);
      #1;
      edges++;
    end
    rd = resp_rdata;
    er = resp_error;
    if (hs) begin
      resp_ready = 1'b1;
      @(posedge SYS_clk);
      #1;
      resp_ready = 1'b0;
    end
  endtask

  int          edges;
  logic [31:0] rd;
  logic        er;
  logic [31:0] ra;
  int          wc0;

  initial begin
    SYS_reset  = 1'b0;
    req_valid  = 1'b0;
    req_funct3 = 3'b000;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;

    repeat (2) @(posedge SYS_clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_we", {31'd0, MEM_write_enable}, 32'd0);
    check("rst_raddr", MEM_read_address, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    @(negedge SYS_clk);
    SYS_reset = 1'b1;
    #1;
    check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    poke(32'h100, 32'h80FF_7F01);

    // Loads from 0x100
    do_req(3'b000, 1'b0, 32'h103, 32'h0, 1'b1, edges, rd, er, ra);
    check("lb_rdata", rd, 32'hFFFF_FF80);
    check("lb_edges", edges, 32'd1);
    check("lb_raddr", ra, 32'h100);
    check("lb_err", {31'd0, er}, 32'd0);
    check("lb_ready_after", {31'd0, req_ready}, 32'd1);
    do_req(3'b100, 1'b0, 32'h103, 32'h0, 1'b1, edges, rd, er, ra);
    check("lbu_rdata", rd, 32'h0000_0080);
    check("lbu_edges", edges, 32'd1);
    do_req(3'b001, 1'b0, 32'h102, 32'h0, 1'b1, edges, rd, er, ra);
    check("lh_rdata", rd, 32'hFFFF_80FF);
    check("lh_edges", edges, 32'd1);
    do_req(3'b101, 1'b0, 32'h100, 32'h0, 1'b1, edges, rd, er, ra);
    check("lhu_rdata", rd, 32'h0000_7F01);

    // SW then LW
    wc0 = wr_count;
    do_req(3'b010, 1'b1, 32'h200, 32'hDEAD_BEEF, 1'b1, edges, rd, er, ra);
    check("sw_pulses", wr_count - wc0, 32'd1);
    check("sw_waddr", last_waddr, 32'h200);
    check("sw_wdata", last_wdata, 32'hDEAD_BEEF);
    check("sw_err", {31'd0, er}, 32'd0);
    check("sw_rdata", rd, 32'd0);
    check("sw_edges", edges, 32'd1);
    do_req(3'b010, 1'b0, 32'h200, 32'h0, 1'b1, edges, rd, er, ra);
    check("lw_rdata", rd, 32'hDEAD_BEEF);

    // Read-modify-write sub-word stores
    poke(32'h200, 32'h1122_3344);
    wc0 = wr_count;
    do_req(3'b000, 1'b1, 32'h201, 32'hFFFF_FFAA, 1'b1, edges, rd, er, ra);
    check("sb_wdata", last_wdata, 32'h1122_AA44);
    check("sb_waddr", last_waddr, 32'h200);
    check("sb_edges", edges, 32'd2);
    check("sb_pulses", wr_count - wc0, 32'd1);
    do_req(3'b001, 1'b1, 32'h202, 32'h1234_BEEF, 1'b1, edges, rd, er, ra);
    check("sh_wdata", last_wdata, 32'hBEEF_AA44);
    check("sh_edges", edges, 32'd2);
    check("sh_mem", mem[32'h200 >> 2], 32'hBEEF_AA44);

    // Errors: misaligned and illegal funct3
    wc0 = wr_count;
    do_req(3'b010, 1'b0, 32'h202, 32'h0, 1'b1, edges, rd, er, ra);
    check("lw_mis_err", {31'd0, er}, 32'd1);
    check("lw_mis_rdata", rd, 32'd0);
    check("lw_mis_edges", edges, 32'd0);
    do_req(3'b001, 1'b1, 32'h203, 32'h5555_5555, 1'b1, edges, rd, er, ra);
    check("sh_mis_err", {31'd0, er}, 32'd1);
    check("sh_mis_rdata", rd, 32'd0);
    do_req(3'b011, 1'b0, 32'h100, 32'h0, 1'b1, edges, rd, er, ra);
    check("f3_011_err", {31'd0, er}, 32'd1);
    do_req(3'b100, 1'b1, 32'h100, 32'h0, 1'b1, edges, rd, er, ra);
    check("sbu_err", {31'd0, er}, 32'd1);
    check("err_pulses", wr_count - wc0, 32'd0);
    check("err_mem", mem[32'h200 >> 2], 32'hBEEF_AA44);

    // Backpressure: response held stable while resp_ready low
    do_req(3'b010, 1'b0, 32'h100, 32'h0, 1'b0, edges, rd, er, ra);
    check("stall_first", rd, 32'h80FF_7F01);
    for (int i = 0; i < 5; i++) begin
      @(posedge SYS_clk);
      #1;
      check("stall_valid", {31'd0, resp_valid}, 32'd1);
      check("stall_rdata", resp_rdata, 32'h80FF_7F01);
      check("stall_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge SYS_clk);
    #1;
    resp_ready = 1'b0;
    check("hs_ready", {31'd0, req_ready}, 32'd1);
    check("hs_valid", {31'd0, resp_valid}, 32'd0);

    // Reset during the WRITE cycle of an SB
    wc0 = wr_count;
    @(negedge SYS_clk);
    req_funct3 = 3'b000;
    req_write  = 1'b1;
    req_addr   = 32'h200;
    req_wdata  = 32'h0000_0055;
    req_valid  = 1'b1;
    @(posedge SYS_clk);
    #1;
    req_valid = 1'b0;
    @(posedge SYS_clk);
    #1;
    check("mid_we_before", {31'd0, MEM_write_enable}, 32'd1);
    SYS_reset = 1'b0;
    #1;
    check("mid_we", {31'd0, MEM_write_enable}, 32'd0);
    check("mid_waddr", MEM_write_address, 32'd0);
    check("mid_wdata", MEM_write_data, 32'd0);
    check("mid_raddr", MEM_read_address, 32'd0);
    check("mid_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("mid_rdata", resp_rdata, 32'd0);
    check("mid_err", {31'd0, resp_error}, 32'd0);
    check("mid_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge SYS_clk);
    #1;
    check("mid_mem", mem[32'h200 >> 2], 32'hBEEF_AA44);
    check("mid_pulses", wr_count - wc0, 32'd0);
    @(negedge SYS_clk);
    SYS_reset = 1'b1;
    do_req(3'b010, 1'b0, 32'h200, 32'h0, 1'b1, edges, rd, er, ra);
    check("post_lw_rdata", rd, 32'hBEEF_AA44);
    check("post_lw_edges", edges, 32'd1);
    check("post_lw_err", {31'd0, er}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
